simple_processor_sequencer: RTL and testbench
=============================================

Name: simple_processor_sequencer

Overview:
- Instruction-issue controller sitting between a host/loader and simple_processor.
- Buffers host instructions in a small FIFO and replays them to the processor's start/write/program_in interface at a fixed, programmable cadence (one instruction per 1+GAP_CYCLES clocks).
- Replaces hand-timed stimulus driving of the processor and gives the host a valid/ready handshake plus occupancy and issue status.

Parameters:
- DEPTH, 8, FIFO entries; power of two, at least 2.
- GAP_CYCLES, 1, idle clocks inserted after each write pulse, range 0..15.
- IW, 23, instruction width; matches the processor program_in width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 = reset asserted
- host_valid  in  1  host offers host_instr
- host_instr  in  IW  instruction word; op in [IW-1:IW-2]
- host_ready  out  1  FIFO can accept a word
- run  in  1  level; permits issuing
- flush  in  1  synchronous clear of FIFO and sequencer
- proc_start  out  1  processor enable
- proc_write  out  1  one-cycle strobe; proc_program valid
- proc_program  out  IW  instruction to processor
- busy  out  1  state != IDLE
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- level  out  clog2(DEPTH)+1  FIFO occupancy
- issued_count  out  16  instructions written to processor; wraps
- halted  out  1  halt sentinel consumed (see Optional Feature)

Behaviour:
- Reset (reset=0, async):
  - FIFO empty, level=0, empty=1, full=0, host_ready=1.
  - State IDLE; proc_start=0, proc_write=0, proc_program=0, issued_count=0, halted=0.
- Push: host_valid & host_ready at the edge. host_ready = !full, with no combinational dependence on pop. Words pushed into an empty FIFO become poppable the next cycle (no bypass).
- Push and pop in the same cycle: level unchanged. When full, no push occurs even if a pop happens that cycle.
- FSM states: IDLE, ISSUE, GAP, HALTED.
  - IDLE -> ISSUE when run & !empty.
  - ISSUE (exactly 1 cycle):
    - Head is popped into the proc_program register; proc_write=1; issued_count+1 (0xFFFF -> 0x0000).
    - Next state: GAP if GAP_CYCLES>0. If GAP_CYCLES=0: ISSUE if run & FIFO will still be non-empty, else IDLE.
  - GAP: proc_write=0, proc_program held. Counter runs GAP_CYCLES clocks, then ISSUE if run & !empty, else IDLE.
  - Deasserting run mid-GAP completes the gap and then goes to IDLE; an ISSUE already in progress always completes.
- Outputs are registered.
  - proc_start=1 in ISSUE and GAP; 0 in IDLE and HALTED.
  - proc_program holds its last value in IDLE.
- Issue latency: run high with FIFO non-empty at edge N puts the FSM in ISSUE after edge N, so proc_write is high for the cycle following edge N.
- flush: takes priority over push, pop and FSM transitions.
  - Next edge: FIFO cleared, state IDLE, proc_write=0, proc_program=0, proc_start=0, halted=0.
  - issued_count is retained.
- Reset asserted mid-operation returns everything to reset values immediately; no partial write strobe is guaranteed.

Optional Feature:
- Macro: SEQ_HALT_EN.
- Defined:
  - A popped word equal to all-ones (23'h7FFFFF) is a halt sentinel. It is not forwarded: proc_write stays 0, proc_program is unchanged, issued_count is unchanged.
  - FSM enters HALTED with halted=1 and proc_start=0, and stays there regardless of run until flush or reset.
  - Push remains allowed while HALTED.
- Undefined: all-ones is forwarded as an ordinary instruction; HALTED is unreachable; halted tied to 0.

Test Plan:
- Reset then idle: reset=0 for 2 cycles, then 1 -> host_ready=1, empty=1, level=0, proc_start=0, proc_program=0, issued_count=0.
- Single load: push 23'h000009, run=1, GAP_CYCLES=1 -> exactly one proc_write pulse with proc_program=23'h000009, proc_start=1 for 2 cycles, then IDLE, issued_count=1.
- Fill and back-pressure: run=0, push 9 words with DEPTH=8 -> host_ready=0 after the 8th, full=1, level=8, 9th word not accepted; then run=1 -> 8 writes spaced exactly 2 clocks apart, in push order.
- Run gating: 4 words queued, deassert run during the GAP after the 2nd write -> gap completes, IDLE, level=2. Reassert run -> remaining 2 words issue.
- Flush mid-stream: 5 words queued, flush=1 during GAP -> next cycle level=0, state IDLE, proc_write=0, proc_start=0, issued_count unchanged.
- SEQ_HALT_EN: push 23'h000001, 23'h7FFFFF, 23'h000002, run=1 -> one write (23'h000001), then halted=1, proc_start=0, level=1. Flush -> halted=0. Without macro, 3 writes, issued_count=3.

Source files
------------

// File: rtl/simple_processor_sequencer.sv
// simple_processor_sequencer: FIFO-buffered instruction issue to simple_processor at a fixed cadence.
// Optional halt sentinel (all-ones word) enabled by defining SEQ_HALT_EN.
module simple_processor_sequencer #(
    parameter int DEPTH      = 8,
    parameter int GAP_CYCLES = 1,
    parameter int IW         = 23
)(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     host_valid,
    input  logic [IW-1:0]            host_instr,
    output logic                     host_ready,
    input  logic                     run,
    input  logic                     flush,
    output logic                     proc_start,
    output logic                     proc_write,
    output logic [IW-1:0]            proc_program,
    output logic                     busy,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              issued_count,
    output logic                     halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [3:0] GLAST = 4'(GAP_CYCLES == 0 ? 0 : GAP_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, GAP, HALTED} state_t;
    state_t        state;
    logic [IW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0]    gcnt;
    logic          push, go, is_halt;
    logic [IW-1:0] head;
    assign head       = mem[rd_ptr];
    assign empty      = level == '0;
    assign full       = level == LW'(DEPTH);
    assign host_ready = !full;
    assign busy       = state != IDLE;
    assign push       = host_valid & host_ready;
    // go: this edge pops the head and enters ISSUE (or HALTED on a sentinel)
    assign go = run & !empty & ((state == IDLE) | (state == ISSUE & GAP_CYCLES == 0) |
                                (state == GAP & gcnt == GLAST));
`ifdef SEQ_HALT_EN
    assign is_halt = head == '1;
`else
    assign is_halt = 1'b0;
`endif
    always_ff @(posedge clk)
        if (push & !flush) mem[wr_ptr] <= host_instr;
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            gcnt         <= '0;
            proc_start   <= 1'b0;
            proc_write   <= 1'b0;
            proc_program <= '0;
            issued_count <= '0;
            halted       <= 1'b0;
        end else if (flush) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            gcnt         <= '0;
            proc_start   <= 1'b0;
            proc_write   <= 1'b0;
            proc_program <= '0;
            halted       <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (go) rd_ptr <= rd_ptr + AW'(1);
            level      <= level + LW'(push) - LW'(go);
            proc_write <= go & !is_halt;
            if (go & !is_halt) begin
                proc_program <= head;
                issued_count <= issued_count + 16'd1;
            end
            halted     <= halted | (go & is_halt);
            gcnt       <= state == GAP ? gcnt + 4'd1 : 4'd0;
            proc_start <= go ? !is_halt : (state == ISSUE & GAP_CYCLES > 0) | (state == GAP & gcnt != GLAST);
            state      <= go ? (is_halt ? HALTED : ISSUE) :
                          state == ISSUE ? (GAP_CYCLES > 0 ? GAP : IDLE) :
                          state == GAP ? (gcnt == GLAST ? IDLE : GAP) : state;
        end
endmodule

// File: tb/tb_simple_processor_sequencer.sv
// tb_simple_processor_sequencer: queue-based model plus directed scenarios for simple_processor_sequencer.
module tb_simple_processor_sequencer;
    localparam int DEPTH = 8, GAP = 1, IW = 23;
    logic clk = 0, reset = 0, host_valid = 0, run = 0, flush = 0;
    logic [IW-1:0] host_instr = '0;
    logic host_ready, proc_start, proc_write, busy, empty, full, halted;
    logic [IW-1:0] proc_program;
    logic [3:0] level;
    logic [15:0] issued_count;
    int passed = 0, total = 0, cyc = 0, wcount = 0;
    logic [IW-1:0] q[$];
    logic prev_h = 0;

    simple_processor_sequencer #(.DEPTH(DEPTH), .GAP_CYCLES(GAP), .IW(IW)) dut (
        .clk(clk), .reset(reset), .host_valid(host_valid), .host_instr(host_instr),
        .host_ready(host_ready), .run(run), .flush(flush), .proc_start(proc_start),
        .proc_write(proc_write), .proc_program(proc_program), .busy(busy), .empty(empty),
        .full(full), .level(level), .issued_count(issued_count), .halted(halted));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Model: FIFO contents as a queue, pushes accepted while fewer than DEPTH words are held
    always @(negedge reset) begin
        q.delete();
        wcount = 0;
    end
    always @(posedge clk)
        if (reset) begin
            if (flush) q.delete();
            else if (host_valid && q.size() < DEPTH) q.push_back(host_instr);
        end
    always @(negedge clk)
        if (reset) begin
            if (proc_write) begin
                if (q.size() == 0) chk("write_from_empty", 1, 0);
                else chk("proc_program", 32'(proc_program), 32'(q.pop_front()));
                wcount++;
                chk("start_with_write", 32'(proc_start), 1);
            end
`ifdef SEQ_HALT_EN
            if (halted && !prev_h) begin
                if (q.size() == 0) chk("halt_from_empty", 1, 0);
                else chk("sentinel", 32'(q.pop_front()), 32'h7FFFFF);
            end
`endif
            prev_h = halted;
            chk("level", 32'(level), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("host_ready", 32'(host_ready), 32'(q.size() < DEPTH));
            chk("issued_count", 32'(issued_count), 32'(16'(wcount)));
        end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [IW-1:0] w);
        host_valid = 1;
        host_instr = w;
        tick();
        host_valid = 0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int seen = 0;
        for (int i = 0; i < budget && seen < n; i++) begin
            tick();
            if (proc_write) seen++;
        end
        if (seen < n) chk("write_timeout", 32'(seen), 32'(n));
    endtask

    initial begin
        int stamps[$];
        tick(); tick();
        chk("rst_ready", 32'(host_ready), 1);
        chk("rst_start", 32'(proc_start), 0);
        reset = 1;
        tick();
        chk("idle_empty", 32'(empty), 1);
        chk("idle_level", 32'(level), 0);
        chk("idle_program", 32'(proc_program), 0);
        chk("idle_issued", 32'(issued_count), 0);
        chk("idle_halted", 32'(halted), 0);
        // single load
        push_word(23'h000009);
        chk("single_level", 32'(level), 1);
        run = 1;
        tick();
        chk("single_write", 32'(proc_write), 1);
        chk("single_prog", 32'(proc_program), 32'h9);
        chk("single_start1", 32'(proc_start), 1);
        tick();
        chk("single_gap_write", 32'(proc_write), 0);
        chk("single_start2", 32'(proc_start), 1);
        tick();
        chk("single_idle_start", 32'(proc_start), 0);
        chk("single_idle_busy", 32'(busy), 0);
        chk("single_issued", 32'(issued_count), 1);
        chk("single_hold_prog", 32'(proc_program), 32'h9);
        run = 0;
        // fill and back-pressure
        host_valid = 1;
        for (int i = 0; i < 9; i++) begin
            host_instr = 23'(32'h100 + i);
            tick();
            chk("fill_ready", 32'(host_ready), 32'(i < 7));
        end
        host_valid = 0;
        chk("fill_full", 32'(full), 1);
        chk("fill_level", 32'(level), 8);
        run = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (proc_write) begin
                chk("fill_order", 32'(proc_program), 32'h100 + 32'(stamps.size()));
                stamps.push_back(cyc);
            end
        end
        chk("fill_writes", 32'(stamps.size()), 8);
        for (int i = 1; i < stamps.size(); i++) chk("fill_spacing", 32'(stamps[i] - stamps[i-1]), 2);
        chk("fill_issued", 32'(issued_count), 9);
        run = 0;
        // run gating
        for (int i = 0; i < 4; i++) push_word(23'(32'h200 + i));
        run = 1;
        wait_writes(2, 20);
        tick();
        chk("gate_in_gap", 32'(proc_start), 1);
        run = 0;
        tick();
        chk("gate_idle", 32'(busy), 0);
        chk("gate_level", 32'(level), 2);
        tick(); tick(); tick();
        chk("gate_level_hold", 32'(level), 2);
        chk("gate_issued", 32'(issued_count), 11);
        run = 1;
        wait_writes(2, 20);
        tick(); tick();
        chk("gate_resume_issued", 32'(issued_count), 13);
        run = 0;
        // flush mid-stream
        for (int i = 0; i < 5; i++) push_word(23'(32'h300 + i));
        run = 1;
        wait_writes(1, 20);
        tick();
        flush = 1;
        tick();
        flush = 0;
        chk("flush_level", 32'(level), 0);
        chk("flush_busy", 32'(busy), 0);
        chk("flush_write", 32'(proc_write), 0);
        chk("flush_start", 32'(proc_start), 0);
        chk("flush_prog", 32'(proc_program), 0);
        chk("flush_issued", 32'(issued_count), 14);
        run = 0;
        tick();
        // halt sentinel
        push_word(23'h000001);
        push_word(23'h7FFFFF);
        push_word(23'h000002);
        run = 1;
        for (int i = 0; i < 12; i++) tick();
`ifdef SEQ_HALT_EN
        chk("halt_flag", 32'(halted), 1);
        chk("halt_start", 32'(proc_start), 0);
        chk("halt_level", 32'(level), 1);
        chk("halt_issued", 32'(issued_count), 15);
        flush = 1;
        tick();
        flush = 0;
        chk("halt_cleared", 32'(halted), 0);
`else
        chk("nohalt_flag", 32'(halted), 0);
        chk("nohalt_level", 32'(level), 0);
        chk("nohalt_issued", 32'(issued_count), 17);
        chk("nohalt_last", 32'(proc_program), 32'h2);
`endif
        run = 0;
        // async reset mid-operation
        push_word(23'h000044);
        push_word(23'h000055);
        run = 1;
        tick();
        #2 reset = 0;
        #1;
        chk("arst_level", 32'(level), 0);
        chk("arst_start", 32'(proc_start), 0);
        chk("arst_write", 32'(proc_write), 0);
        chk("arst_issued", 32'(issued_count), 0);
        chk("arst_prog", 32'(proc_program), 0);
        run = 0;
        tick();
        reset = 1;
        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
